// File: rtl/instr_encoder.sv
// instr_encoder: packs one symbolic MIPS instruction per handshake into a
// 32-bit word, tags it with a sequential word address and buffers it in a
// 2-entry output FIFO feeding the instruction-memory loader.
// Optional feature macro: ENC_NOP_PAD_EN -- when defined, every accepted
// beq/j/jal/jr is followed by a delay-slot NOP word at the next address.
module instr_encoder #(
    parameter int          AW   = 10,
    parameter int unsigned BASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic [AW-1:0] out_addr,
    output logic          err
);

    localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    localparam logic [3:0] OP_ADDU  = 4'd0;
    localparam logic [3:0] OP_SUBU  = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_JR    = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LW    = 4'd6;
    localparam logic [3:0] OP_SW    = 4'd7;
    localparam logic [3:0] OP_BEQ   = 4'd8;
    localparam logic [3:0] OP_LUI   = 4'd9;
    localparam logic [3:0] OP_J     = 4'd10;
    localparam logic [3:0] OP_ADDI  = 4'd11;
    localparam logic [3:0] OP_ADDIU = 4'd12;
    localparam logic [3:0] OP_JAL   = 4'd13;

`ifdef ENC_NOP_PAD_EN
    typedef enum logic {ENC, PAD} state_t;
`else
    typedef enum logic {ENC} state_t;
`endif

    state_t state_q, state_d;

    // FIFO storage and control
    logic [31:0]   word_mem_q [2];
    logic [AW-1:0] addr_mem_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_cnt_q;
    logic          err_q, err_d;

    logic          push, pop;
    logic [31:0]   push_word;

    // Codes 14 and 15 are the only undefined operations.
    function automatic logic op_is_valid(input logic [3:0] op);
        return (op <= OP_JAL);
    endfunction

    // Pack the fields into a MIPS word; forced-zero fields ignore their inputs.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'h0;
        case (op)
            OP_ADDU:  w = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            OP_SUBU:  w = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            OP_SLT:   w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            OP_JR:    w = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            OP_SLL:   w = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
            OP_ORI:   w = {6'h0D, rs, rt, imm};
            OP_LW:    w = {6'h23, rs, rt, imm};
            OP_SW:    w = {6'h2B, rs, rt, imm};
            OP_BEQ:   w = {6'h04, rs, rt, imm};
            OP_LUI:   w = {6'h0F, 5'd0, rt, imm};
            OP_J:     w = {6'h02, target};
            OP_ADDI:  w = {6'h08, rs, rt, imm};
            OP_ADDIU: w = {6'h09, rs, rt, imm};
            OP_JAL:   w = {6'h03, target};
            default:  w = 32'h0;
        endcase
        return w;
    endfunction

`ifdef ENC_NOP_PAD_EN
    // Control transfers that need a delay-slot NOP behind them.
    function automatic logic op_needs_pad(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
    endfunction
`endif

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_word  = out_valid ? word_mem_q[rd_ptr_q] : 32'h0;
    assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign err       = err_q;

    // Next-state, handshake and push decisions for the encoder FSM
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        push      = 1'b0;
        push_word = 32'h0;
        err_d     = err_q;
        case (state_q)
            ENC: begin
                in_ready = (cnt_q < 2'd2) && !flush && !reset;
                if (in_valid && in_ready) begin
                    if (op_is_valid(in_op)) begin
                        push      = 1'b1;
                        push_word = encode(in_op, in_rs, in_rt, in_rd, in_shamt,
                                           in_imm, in_target);
`ifdef ENC_NOP_PAD_EN
                        if (op_needs_pad(in_op)) begin
                            state_d = PAD;
                        end
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef ENC_NOP_PAD_EN
            PAD: begin
                // A pop in this cycle frees a slot just as well as count<2.
                if ((cnt_q < 2'd2) || pop) begin
                    push      = 1'b1;
                    push_word = 32'h0;
                    state_d   = ENC;
                end
            end
`endif
            default: state_d = ENC;
        endcase
    end

    // FIFO occupancy follows push/pop; simultaneous push and pop cancel.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FSM state register; reset and flush both return to ENC
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= ENC;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO pointers, occupancy, address counter and sticky error
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            addr_cnt_q <= BASE_ADDR;
            err_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (push) begin
                wr_ptr_q   <= ~wr_ptr_q;
                addr_cnt_q <= addr_cnt_q + ADDR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO data slots; contents are masked by out_valid so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem_q[wr_ptr_q] <= push_word;
            addr_mem_q[wr_ptr_q] <= addr_cnt_q;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, back-pressure, invalid op,
// delay-slot padding, address wrap (second instance with AW=2) and flush.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, out_valid, err;
    logic [31:0] out_word;
    logic [9:0]  out_addr;

    logic        in_ready2, out_valid2, err2;
    logic [31:0] out_word2;
    logic [1:0]  out_addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.AW(10), .BASE(0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .err(err)
    );

    instr_encoder #(.AW(2), .BASE(0)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_word(out_word2), .out_addr(out_addr2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] sh, input logic [15:0] imm,
                              input logic [25:0] tgt);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt);
        set_fields(op, rs, rt, rd, sh, imm, tgt);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);

        // Reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        tick();

        // Basic and remaining encodings, streaming with out_ready high
        out_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("addu_valid", out_valid, 1'b1);
        chk("addu_word", out_word, 32'h00221821);
        chk("addu_addr", out_addr, 32'd0);
        send(4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
        chk("ori_word", out_word, 32'h34011234);
        chk("ori_addr", out_addr, 32'd1);
        send(4'd6, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004, 26'h0);
        chk("lw_word", out_word, 32'h8C220004);
        chk("lw_addr", out_addr, 32'd2);
        send(4'd9, 5'd7, 5'd1, 5'd0, 5'd0, 16'hABCD, 26'h0);
        chk("lui_word", out_word, 32'h3C01ABCD);
        send(4'd4, 5'd5, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
        chk("sll_word", out_word, 32'h00021900);
        chk("sll_addr", out_addr, 32'd4);
        send(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
        chk("jal_word", out_word, 32'h0C000100);
        chk("jal_addr", out_addr, 32'd5);
        tick();
`ifdef ENC_NOP_PAD_EN
        chk("jal_pad_valid", out_valid, 1'b1);
        chk("jal_pad_word", out_word, 32'h0);
        chk("jal_pad_addr", out_addr, 32'd6);
`else
        chk("jal_nopad_valid", out_valid, 1'b0);
`endif
        chk("enc_err", err, 1'b0);

        // Back-pressure: four cycles of in_valid with the consumer stalled
        do_reset();
        out_ready = 1'b0;
        set_fields(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_rd = 5'(3 + i);
            #1;
            chk("bp_in_ready", in_ready, (i < 2));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_head_valid", out_valid, 1'b1);
        chk("bp_head_word", out_word, 32'h00221821);
        chk("bp_head_addr", out_addr, 32'd0);
        tick();
        chk("bp_hold_word", out_word, 32'h00221821);
        out_ready = 1'b1;
        tick();
        chk("bp_second_word", out_word, 32'h00222021);
        chk("bp_second_addr", out_addr, 32'd1);
        tick();
        chk("bp_drained", out_valid, 1'b0);

        // Invalid op then addu
        do_reset();
        out_ready = 1'b1;
        send(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("inv_err", err, 1'b1);
        chk("inv_no_word", out_valid, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("inv_addu_word", out_word, 32'h00221821);
        chk("inv_addu_addr", out_addr, 32'd0);
        tick();
        chk("inv_no_extra", out_valid, 1'b0);
        chk("inv_err_sticky", err, 1'b1);

        // Branch followed by ori
        do_reset();
        out_ready = 1'b1;
        send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        chk("beq_word", out_word, 32'h1022FFFF);
        chk("beq_addr", out_addr, 32'd0);
        set_fields(4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
        in_valid = 1'b1;
        #1;
`ifdef ENC_NOP_PAD_EN
        chk("pad_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("pad_nop_word", out_word, 32'h0);
        chk("pad_nop_addr", out_addr, 32'd1);
        #1;
        chk("pad_in_ready_back", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pad_ori_word", out_word, 32'h34011234);
        chk("pad_ori_addr", out_addr, 32'd2);
`else
        chk("nopad_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("nopad_ori_word", out_word, 32'h34011234);
        chk("nopad_ori_addr", out_addr, 32'd1);
`endif

        // Address wrap on the AW=2 instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(4'd1, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0);
            chk("wrap_addr2", out_addr2, 32'(i % 4));
            chk("wrap_addr", out_addr, 32'(i));
            chk("wrap_word2", out_word2, {16'h0022, 5'(i), 11'h023});
        end

        // Flush with two words buffered and a sticky error set
        do_reset();
        out_ready = 1'b0;
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        send(4'd0, 5'd1, 5'd2, 5'd4, 5'd0, 16'h0, 26'h0);
        chk("fl_pre_valid", out_valid, 1'b1);
        chk("fl_pre_err", err, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_err", err, 1'b0);

        // Flush together with in_valid: the instruction is refused
        flush = 1'b1;
        set_fields(4'd0, 5'd1, 5'd2, 5'd7, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_not_accepted", out_valid, 1'b0);
        out_ready = 1'b1;
        send(4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("fl_slt_word", out_word, 32'h0022182A);
        chk("fl_slt_addr", out_addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder: the inverse of the single-cycle controller's opcode/funct decode. It accepts one symbolic instruction per handshake (operation code plus register, shift, immediate and target fields) and packs it into a 32-bit MIPS word. Each word is tagged with a sequential word address and buffered in a 2-entry output FIFO that drives the instruction-memory loader. It is used by the test-program loader and the self-check harness for the P-series CPUs.

## Interface

Parameters:
- AW, 10: width of the word-address counter.
- BASE, 0: word address given to the first word after reset or flush.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of FIFO, address, state and err; reset values apply.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  encoder can accept an instruction.
- in_op  in  4  0 addu, 1 subu, 2 slt, 3 jr, 4 sll, 5 ori, 6 lw, 7 sw, 8 beq, 9 lui, 10 j, 11 addi, 12 addiu, 13 jal; 14–15 are invalid.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head word.
- out_word  out  32  encoded instruction.
- out_addr  out  AW  word address of out_word.
- err  out  1  sticky; set when an invalid op is accepted.

## Operation

- Encoding:
  - R-type is {6'h00, rs, rt, rd, shamt, funct}. Funct codes: addu 0x21, subu 0x23, slt 0x2A, jr 0x08, sll 0x00.
  - addu, subu and slt force shamt to 0.
  - sll forces rs to 0.
  - jr forces rt, rd and shamt to 0.
  - I-type is {op, rs, rt, imm}. Opcodes: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, addi 0x08, addiu 0x09. lui forces rs to 0.
  - J-type is {op, target}. Opcodes: j 0x02, jal 0x03.
- A transfer occurs when in_valid and in_ready are both high. A valid op pushes {word, addr_cnt} into the FIFO and increments addr_cnt, which wraps modulo 2^AW.
- An invalid op completes its handshake but pushes nothing. It sets err and leaves addr_cnt unchanged.
- FIFO:
  - 2 entries; count ranges 0–2.
  - A pop occurs when out_valid and out_ready are both high.
  - Push and pop in the same cycle leave count unchanged.
  - out_word and out_addr are held stable while out_valid is high and out_ready is low.
- State machine: ENC and PAD; PAD exists only when the feature below is compiled in.
  - in_ready = (state==ENC) && (count<2) && !flush.
- Priority order: reset, then flush, then normal operation. Reset or flush mid-stream discards FIFO contents; the next accepted word gets address BASE.
- Reset values:
  - in_ready 1 from the first cycle after reset deassertion; 0 while reset is high.
  - out_valid 0, out_word 0, out_addr 0, err 0, state ENC, addr_cnt BASE.

## Timing

- Latency: an instruction accepted at edge N appears on out_word with out_valid high after edge N. That is one cycle when the FIFO is empty.
- Throughput: one word per cycle when out_ready is held high.
- Back-pressure: with count==2 and no pop, in_ready is low in that cycle. in_ready is a registered-state function, with no combinational path from out_ready.
- err rises the cycle after the invalid op is accepted.

## Configuration

- ENC_NOP_PAD_EN defined: after accepting beq, j, jal or jr, the state goes to PAD.
  - In PAD, in_ready is 0.
  - The NOP word 0x00000000 is pushed, with the next address, on the first cycle with count<2 (a simultaneous pop counts as space), after which the state returns to ENC.
  - Result: every branch or jump is followed by a delay-slot NOP at address+1.
- ENC_NOP_PAD_EN undefined: no PAD state and no padding.

## Test plan

- Basic encodings: addu rs=1 rt=2 rd=3 → 0x00221821 @BASE; ori rt=1 imm=0x1234 → 0x34011234 @BASE+1; lw rs=1 rt=2 imm=4 → 0x8C220004.
- Remaining formats:
  - lui rt=1 imm=0xABCD with in_rs=7 → 0x3C01ABCD (rs forced 0).
  - jal target=0x100 → 0x0C000100.
  - sll rt=2 rd=3 shamt=4 with in_rs=5 → 0x00021900.
- Back-pressure: out_ready=0 while in_valid=1 for 4 cycles → exactly 2 words accepted, in_ready low from the 3rd cycle. Then out_ready=1 → words drain in order with addresses BASE, BASE+1.
- Invalid op 15 then addu → err=1, the addu gets address BASE (not BASE+1), and no extra word appears.
- Padding: beq rs=1 rt=2 imm=0xFFFF then ori → with ENC_NOP_PAD_EN: 0x1022FFFF @0, 0x00000000 @1, ori @2, and in_ready low for 1 cycle. Without the macro: ori @1.
- Wrap and flush:
  - AW=2: 5 words → addresses 0, 1, 2, 3, 0.
  - flush asserted with 2 words buffered → out_valid 0 and err 0 on the next cycle, and the next word gets address BASE.
  - flush asserted together with in_valid → that instruction is not accepted.
